gnrl_pipe_skid: RTL and testbench

// Two-entry valid/ready pipeline register slice (skid buffer) for the core's pipeline stages.

---
 rtl/gnrl_pipe_skid.sv | 224 ++++++++++++++++++++++
 tb/tb_gnrl_pipe_skid.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gnrl_pipe_skid.sv
// Two-entry valid/ready register slice (skid buffer) built from the general DFF cells.
// i_ready depends only on the held-entry count, so no combinational ready path crosses the slice.

module gnrl_dffr #(
    parameter int            DW      = 1,
    parameter logic [DW-1:0] RST_VAL = {DW{1'b0}}
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] dnxt,
    output logic [DW-1:0] qout
);

    logic [DW-1:0] q_r;

    // Plain register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r <= RST_VAL;
        end else begin
            q_r <= dnxt;
        end
    end

    assign qout = q_r;

endmodule

module gnrl_dfflr #(
    parameter int            DW      = 1,
    parameter logic [DW-1:0] RST_VAL = {DW{1'b0}}
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          lden,
    input  logic [DW-1:0] dnxt,
    output logic [DW-1:0] qout
);

    logic [DW-1:0] q_r;

    // Load-enable register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r <= RST_VAL;
        end else if (lden) begin
            q_r <= dnxt;
        end else begin
            q_r <= q_r;
        end
    end

    assign qout = q_r;

endmodule

module gnrl_pipe_skid_chk #(
    parameter int WIDTH = 32
) (
    input logic             clk,
    input logic             rst_n,
    input logic             flush,
    input logic             i_ready,
    input logic             o_valid,
    input logic             o_ready,
    input logic [WIDTH-1:0] o_data,
    input logic [1:0]       o_count
);

    a_count_legal: assert property (@(posedge clk) disable iff (!rst_n)
        o_count != 2'd3);

    a_ready_matches_count: assert property (@(posedge clk) disable iff (!rst_n)
        i_ready == (o_count != 2'd2));

    a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (o_valid && !o_ready && !flush) |=> (o_valid && $stable(o_data)));

endmodule

module gnrl_pipe_skid #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [WIDTH-1:0] o_data,
    output logic [1:0]       o_count
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    logic [1:0]       state_q_s;
    state_e           state_s;
    state_e           nxt_state_s;
    logic             in_fire_s;
    logic             out_fire_s;
    logic             main_ld_s;
    logic             skid_ld_s;
    logic [WIDTH-1:0] main_nxt_s;
    logic [WIDTH-1:0] main_r;
    logic [WIDTH-1:0] skid_r;

    gnrl_dffr #(
        .DW      (2),
        .RST_VAL (2'd0)
    ) u_state (
        .clk   (clk),
        .rst_n (rst_n),
        .dnxt  (nxt_state_s),
        .qout  (state_q_s)
    );

    gnrl_dfflr #(
        .DW      (WIDTH),
        .RST_VAL (RESET_VAL)
    ) u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .lden  (main_ld_s),
        .dnxt  (main_nxt_s),
        .qout  (main_r)
    );

    gnrl_dfflr #(
        .DW      (WIDTH),
        .RST_VAL (RESET_VAL)
    ) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .lden  (skid_ld_s),
        .dnxt  (i_data),
        .qout  (skid_r)
    );

    // Decode the raw count; the unused encoding 3 behaves as EMPTY.
    always_comb begin
        state_s = ST_EMPTY;
        case (state_q_s)
            2'd1:    state_s = ST_ONE;
            2'd2:    state_s = ST_FULL;
            default: state_s = ST_EMPTY;
        endcase
    end

    assign o_valid    = (state_s != ST_EMPTY);
    assign i_ready    = (state_s != ST_FULL);
    assign o_data     = main_r;
    assign o_count    = state_s;
    assign in_fire_s  = i_valid & i_ready;
    assign out_fire_s = o_valid & o_ready;

    // Next count and register loads; flush wins and suppresses all loads.
    always_comb begin
        nxt_state_s = state_s;
        main_ld_s   = 1'b0;
        skid_ld_s   = 1'b0;
        main_nxt_s  = i_data;
        if (flush) begin
            nxt_state_s = ST_EMPTY;
        end else begin
            case (state_s)
                ST_EMPTY: begin
                    if (in_fire_s) begin
                        nxt_state_s = ST_ONE;
                        main_ld_s   = 1'b1;
                    end else begin
                        nxt_state_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (in_fire_s && out_fire_s) begin
                        nxt_state_s = ST_ONE;
                        main_ld_s   = 1'b1;
                    end else if (in_fire_s) begin
                        // Skid holds the newer entry; main stays at the head.
                        nxt_state_s = ST_FULL;
                        skid_ld_s   = 1'b1;
                    end else if (out_fire_s) begin
                        nxt_state_s = ST_EMPTY;
                    end else begin
                        nxt_state_s = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (out_fire_s) begin
                        nxt_state_s = ST_ONE;
                        main_ld_s   = 1'b1;
                        main_nxt_s  = skid_r;
                    end else begin
                        nxt_state_s = ST_FULL;
                    end
                end
                default: begin
                    nxt_state_s = ST_EMPTY;
                end
            endcase
        end
    end

    gnrl_pipe_skid_chk #(
        .WIDTH (WIDTH)
    ) u_chk (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .i_ready (i_ready),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_count (o_count)
    );

endmodule

// File: tb/tb_gnrl_pipe_skid.sv
// Directed and scoreboarded checks for gnrl_pipe_skid.
// Inputs change and outputs are sampled 1 ns after each rising edge.

module tb_gnrl_pipe_skid;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             flush = 1'b0;
    logic             i_valid = 1'b0;
    logic             i_ready;
    logic [WIDTH-1:0] i_data = 32'h0;
    logic             o_valid;
    logic             o_ready = 1'b0;
    logic [WIDTH-1:0] o_data;
    logic [1:0]       o_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    gnrl_pipe_skid #(
        .WIDTH     (WIDTH),
        .RESET_VAL (32'h0)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .i_data  (i_data),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_count (o_count)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        #2;
        n_vec++;
        if ({o_valid, i_ready, o_count, o_data} !== {1'b0, 1'b1, 2'd0, 32'h0}) begin
            n_err++;
            $display("FAIL reset: got %h want %h", {o_valid, i_ready, o_count, o_data},
                     {1'b0, 1'b1, 2'd0, 32'h0});
        end
        tick;
        tick;
        rst_n = 1'b1;
        tick;
        n_vec++;
        if ({o_valid, i_ready, o_count} !== {1'b0, 1'b1, 2'd0}) begin
            n_err++;
            $display("FAIL reset_idle: got %b want %b", {o_valid, i_ready, o_count}, 4'b0100);
        end
    endtask

    task automatic test_stream;
        logic [WIDTH-1:0] vals [3];
        vals[0] = 32'h11;
        vals[1] = 32'h22;
        vals[2] = 32'h33;
        o_ready = 1'b1;
        i_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            i_data = vals[i];
            tick;
            n_vec++;
            if ({o_valid, i_ready, o_count, o_data} !== {1'b1, 1'b1, 2'd1, vals[i]}) begin
                n_err++;
                $display("FAIL stream[%0d]: got %h want %h", i,
                         {o_valid, i_ready, o_count, o_data}, {1'b1, 1'b1, 2'd1, vals[i]});
            end
        end
        i_valid = 1'b0;
        tick;
        n_vec++;
        if ({o_valid, i_ready, o_count} !== {1'b0, 1'b1, 2'd0}) begin
            n_err++;
            $display("FAIL stream_end: got %b want %b", {o_valid, i_ready, o_count}, 4'b0100);
        end
    endtask

    task automatic test_backpressure;
        o_ready = 1'b0;
        i_valid = 1'b1;
        i_data  = 32'hA1;
        tick;
        n_vec++;
        if ({o_valid, i_ready, o_count, o_data} !== {1'b1, 1'b1, 2'd1, 32'hA1}) begin
            n_err++;
            $display("FAIL bp_one: got %h want %h", {o_valid, i_ready, o_count, o_data},
                     {1'b1, 1'b1, 2'd1, 32'hA1});
        end
        i_data = 32'hA2;
        tick;
        i_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if ({o_valid, i_ready, o_count, o_data} !== {1'b1, 1'b0, 2'd2, 32'hA1}) begin
                n_err++;
                $display("FAIL bp_full[%0d]: got %h want %h", i,
                         {o_valid, i_ready, o_count, o_data}, {1'b1, 1'b0, 2'd2, 32'hA1});
            end
            tick;
        end
        o_ready = 1'b1;
        tick;
        n_vec++;
        if ({o_valid, i_ready, o_count, o_data} !== {1'b1, 1'b1, 2'd1, 32'hA2}) begin
            n_err++;
            $display("FAIL bp_drain1: got %h want %h", {o_valid, i_ready, o_count, o_data},
                     {1'b1, 1'b1, 2'd1, 32'hA2});
        end
        tick;
        n_vec++;
        if ({o_valid, i_ready, o_count} !== {1'b0, 1'b1, 2'd0}) begin
            n_err++;
            $display("FAIL bp_drain2: got %b want %b", {o_valid, i_ready, o_count}, 4'b0100);
        end
    endtask

    task automatic test_full_ignore;
        o_ready = 1'b0;
        i_valid = 1'b1;
        i_data  = 32'hB1;
        tick;
        i_data = 32'hB2;
        tick;
        i_data = 32'hBB;
        for (int i = 0; i < 3; i++) begin
            tick;
            n_vec++;
            if ({o_valid, i_ready, o_count, o_data} !== {1'b1, 1'b0, 2'd2, 32'hB1}) begin
                n_err++;
                $display("FAIL full_ignore[%0d]: got %h want %h", i,
                         {o_valid, i_ready, o_count, o_data}, {1'b1, 1'b0, 2'd2, 32'hB1});
            end
        end
        i_valid = 1'b0;
        o_ready = 1'b1;
        tick;
        n_vec++;
        if ({o_valid, o_count, o_data} !== {1'b1, 2'd1, 32'hB2}) begin
            n_err++;
            $display("FAIL full_drain1: got %h want %h", {o_valid, o_count, o_data},
                     {1'b1, 2'd1, 32'hB2});
        end
        tick;
        n_vec++;
        if ({o_valid, i_ready, o_count} !== {1'b0, 1'b1, 2'd0}) begin
            n_err++;
            $display("FAIL full_drain2: got %b want %b", {o_valid, i_ready, o_count}, 4'b0100);
        end
    endtask

    task automatic test_flush;
        o_ready = 1'b0;
        i_valid = 1'b1;
        i_data  = 32'hC1;
        tick;
        i_data = 32'hC2;
        tick;
        n_vec++;
        if ({o_valid, i_ready, o_count, o_data} !== {1'b1, 1'b0, 2'd2, 32'hC1}) begin
            n_err++;
            $display("FAIL flush_fill: got %h want %h", {o_valid, i_ready, o_count, o_data},
                     {1'b1, 1'b0, 2'd2, 32'hC1});
        end
        flush   = 1'b1;
        i_data  = 32'hCC;
        o_ready = 1'b1;
        tick;
        flush   = 1'b0;
        i_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if ({o_valid, i_ready, o_count} !== {1'b0, 1'b1, 2'd0}) begin
                n_err++;
                $display("FAIL flush_full[%0d]: got %b want %b", i,
                         {o_valid, i_ready, o_count}, 4'b0100);
            end
            tick;
        end
        // flush from ONE while a new input is accepted in the same cycle
        o_ready = 1'b0;
        i_valid = 1'b1;
        i_data  = 32'hD1;
        tick;
        flush  = 1'b1;
        i_data = 32'hDD;
        tick;
        flush   = 1'b0;
        i_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if ({o_valid, i_ready, o_count} !== {1'b0, 1'b1, 2'd0}) begin
                n_err++;
                $display("FAIL flush_one[%0d]: got %b want %b", i,
                         {o_valid, i_ready, o_count}, 4'b0100);
            end
            tick;
        end
        o_ready = 1'b1;
        i_valid = 1'b1;
        i_data  = 32'hE5;
        tick;
        i_valid = 1'b0;
        n_vec++;
        if ({o_valid, i_ready, o_count, o_data} !== {1'b1, 1'b1, 2'd1, 32'hE5}) begin
            n_err++;
            $display("FAIL flush_after: got %h want %h", {o_valid, i_ready, o_count, o_data},
                     {1'b1, 1'b1, 2'd1, 32'hE5});
        end
        tick;
    endtask

    task automatic test_random;
        logic [WIDTH-1:0] q [$];
        logic [WIDTH-1:0] exp_data;
        logic [WIDTH-1:0] data_prev;
        logic             stall_prev;
        logic             in_f;
        logic             out_f;
        logic             exp_valid;
        logic             exp_ready;
        logic [1:0]       exp_count;
        int               guard;
        stall_prev = 1'b0;
        data_prev  = 32'h0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            exp_valid = (q.size() != 0);
            exp_ready = (q.size() < 2);
            exp_count = 2'(q.size());
            n_vec++;
            if ({o_valid, i_ready, o_count} !== {exp_valid, exp_ready, exp_count}) begin
                n_err++;
                $display("FAIL rand_state@%0d: got %b want %b", cyc,
                         {o_valid, i_ready, o_count}, {exp_valid, exp_ready, exp_count});
            end
            if (stall_prev) begin
                n_vec++;
                if ({o_valid, o_data} !== {1'b1, data_prev}) begin
                    n_err++;
                    $display("FAIL rand_stable@%0d: got %h want %h", cyc,
                             {o_valid, o_data}, {1'b1, data_prev});
                end
            end
            i_valid = 1'($urandom_range(0, 1));
            o_ready = 1'($urandom_range(0, 1));
            i_data  = $urandom;
            in_f    = i_valid & i_ready;
            out_f   = o_valid & o_ready;
            if (out_f) begin
                n_vec++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL rand_spurious@%0d: got %h want no output", cyc, o_data);
                end else begin
                    exp_data = q.pop_front();
                    if (o_data !== exp_data) begin
                        n_err++;
                        $display("FAIL rand_data@%0d: got %h want %h", cyc, o_data, exp_data);
                    end
                end
            end
            if (in_f) begin
                q.push_back(i_data);
            end
            stall_prev = o_valid & ~o_ready;
            data_prev  = o_data;
            tick;
        end
        i_valid = 1'b0;
        o_ready = 1'b1;
        guard   = 0;
        while (q.size() != 0 && guard < 8) begin
            if (o_valid) begin
                exp_data = q.pop_front();
                n_vec++;
                if (o_data !== exp_data) begin
                    n_err++;
                    $display("FAIL rand_drain: got %h want %h", o_data, exp_data);
                end
            end
            tick;
            guard++;
        end
        n_vec++;
        if ({o_valid, (q.size() == 0)} !== 2'b01) begin
            n_err++;
            $display("FAIL rand_empty: got o_valid=%b left=%0d want o_valid=0 left=0",
                     o_valid, q.size());
        end
    endtask

    task automatic test_async_reset;
        o_ready = 1'b0;
        i_valid = 1'b1;
        i_data  = 32'hE1;
        tick;
        i_valid = 1'b0;
        n_vec++;
        if ({o_valid, o_count, o_data} !== {1'b1, 2'd1, 32'hE1}) begin
            n_err++;
            $display("FAIL arst_pre: got %h want %h", {o_valid, o_count, o_data},
                     {1'b1, 2'd1, 32'hE1});
        end
        #3;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({o_valid, i_ready, o_count, o_data} !== {1'b0, 1'b1, 2'd0, 32'h0}) begin
            n_err++;
            $display("FAIL arst_now: got %h want %h", {o_valid, i_ready, o_count, o_data},
                     {1'b0, 1'b1, 2'd0, 32'h0});
        end
        tick;
        tick;
        rst_n = 1'b1;
        tick;
        test_stream();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_full_ignore();
        test_flush();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
